// File: rtl/sound_dac.sv
// 1-bit audio DAC: turns the 8-bit sound level into a pin stream for an RC filter,
// using either 256-step frame PWM or a first-order sigma-delta modulator.
module sound_dac #(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sound,
    input  logic       mode,
    input  logic       mute,
    output logic       dac_out,
    output logic       frame_start
);

    localparam logic [15:0] DivLast = 16'(DIV - 1);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  held_q, held_d;
    logic        mode_q;
    logic        dac_q, dac_d;
    logic        fs_q, fs_d;

    logic [7:0]  target;
    logic        ce;
    logic        mode_chg;
    logic        frame_end;
    logic [8:0]  sum;

    always_comb begin
        target    = mute ? 8'h00 : sound;
        ce        = (presc_q == DivLast);
        mode_chg  = (mode != mode_q);
        frame_end = (cnt_q == 8'hFF);
        sum       = {1'b0, acc_q} + {1'b0, held_q};
    end

    always_comb begin
        presc_d = ce ? 16'd0 : presc_q + 16'd1;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        held_d  = held_q;
        dac_d   = dac_q;
        fs_d    = 1'b0;

        if (mode_chg) begin
            // Restart both modulators cleanly so the new mode begins from a known state.
            presc_d = 16'd0;
            cnt_d   = 8'd0;
            acc_d   = 8'd0;
            held_d  = target;
            dac_d   = 1'b0;
        end else if (ce) begin
            cnt_d = cnt_q + 8'd1;
            fs_d  = frame_end;
            if (mode_q) begin
                held_d = target;
                acc_d  = sum[7:0];
                dac_d  = sum[8];
            end else begin
                dac_d = (cnt_q < held_q);
                // Latch only at the wrap so a frame never mixes two levels.
                if (frame_end) begin
                    held_d = target;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
            cnt_q   <= 8'd0;
            acc_q   <= 8'd0;
            held_q  <= 8'd0;
            mode_q  <= 1'b0;
            dac_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            held_q  <= held_d;
            mode_q  <= mode;
            dac_q   <= dac_d;
            fs_q    <= fs_d;
        end
    end

    assign dac_out     = dac_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sound_dac.sv
// Directed bench for sound_dac: PWM, sigma-delta, prescaler, mode switch, mute and reset.
module tb_sound_dac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sound;
    logic       mode;
    logic       mute;
    logic       dac_out;
    logic       frame_start;
    logic [7:0] sound3;
    logic       mode3;
    logic       mute3;
    logic       dac3;
    logic       fs3;

    int n_checks = 0;
    int n_errors = 0;
    logic trace [0:1023];

    always #5 clk = ~clk;

    sound_dac #(.DIV(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sound      (sound),
        .mode       (mode),
        .mute       (mute),
        .dac_out    (dac_out),
        .frame_start(frame_start)
    );

    sound_dac #(.DIV(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sound      (sound3),
        .mode       (mode3),
        .mute       (mute3),
        .dac_out    (dac3),
        .frame_start(fs3)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n clocks, sampling 1 time unit after each edge.
    task automatic run(input int n, input bit sel3, output int highs, output int first_hi,
                       output int last_hi, output int fs_cnt, output int last_fs);
        logic d;
        logic f;
        highs    = 0;
        first_hi = -1;
        last_hi  = -1;
        fs_cnt   = 0;
        last_fs  = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            d = sel3 ? dac3 : dac_out;
            f = sel3 ? fs3 : frame_start;
            if (i < 1024) trace[i] = d;
            if (d === 1'b1) begin
                highs++;
                if (first_hi < 0) first_hi = i;
                last_hi = i;
            end
            if (f === 1'b1) begin
                fs_cnt++;
                last_fs = i;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int h, fh, lh, fc, lf, h2;
        logic [7:0] pat;

        rst_n  = 1'b0;
        sound  = 8'h80;
        mode   = 1'b0;
        mute   = 1'b0;
        sound3 = 8'h02;
        mode3  = 1'b0;
        mute3  = 1'b0;
        tick();
        tick();
        check_eq("rst_dac", dac_out, 0);
        check_eq("rst_fs", frame_start, 0);
        check_eq("rst_cnt", u_dut.cnt_q, 0);
        check_eq("rst_dac3", dac3, 0);
        rst_n = 1'b1;

        // PWM 0x80 from reset: frame 1 empty, frame 2 half duty.
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pwm80_f1_highs", h, 0);
        check_eq("pwm80_f1_fs_cnt", fc, 1);
        check_eq("pwm80_f1_fs_pos", lf, 255);
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pwm80_f2_highs", h, 128);
        check_eq("pwm80_f2_first", fh, 0);
        check_eq("pwm80_f2_last", lh, 127);
        check_eq("pwm80_f2_fs_cnt", fc, 1);
        check_eq("pwm80_f2_fs_pos", lf, 255);

        // PWM extremes; each new level is visible one frame later.
        sound = 8'h00;
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pwm00_latency_highs", h, 128);
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pwm00_highs", h, 0);
        sound = 8'hFF;
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pwmff_latency_highs", h, 0);
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pwmff_highs", h, 255);
        check_eq("pwmff_last", lh, 254);

        // Level change mid-frame must not disturb the running frame.
        sound = 8'h40;
        run(256, 0, h, fh, lh, fc, lf);
        run(16, 0, h, fh, lh, fc, lf);
        sound = 8'hC0;
        run(240, 0, h2, fh, lh, fc, lf);
        check_eq("pwm40_midchg_highs", h + h2, 64);
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pwmc0_highs", h, 192);
        check_eq("pwmc0_last", lh, 191);

        // Switch to sigma-delta at cnt=0x37.
        run(8'h37, 0, h, fh, lh, fc, lf);
        check_eq("pre_toggle_dac", dac_out, 1);
        mode = 1'b1;
        tick();
        check_eq("toggle_dac", dac_out, 0);
        check_eq("toggle_fs", frame_start, 0);
        check_eq("toggle_cnt", u_dut.cnt_q, 0);
        check_eq("toggle_acc", u_dut.acc_q, 0);
        run(4, 0, h, fh, lh, fc, lf);
        pat = 8'h00;
        for (int i = 0; i < 4; i++) pat = {pat[6:0], trace[i]};
        check_eq("sdm_c0_pattern", pat, 8'b0000_0111);
        check_eq("sdm_c0_cnt", u_dut.cnt_q, 4);
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("sdm_c0_highs", h, 192);

        // Sigma-delta 0x40 straight out of reset.
        tick();
        rst_n = 1'b0;
        sound = 8'h40;
        tick();
        rst_n = 1'b1;
        run(1, 0, h, fh, lh, fc, lf);
        check_eq("sdm40_modechg_dac", h, 0);
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("sdm40_highs", h, 64);
        pat = 8'h00;
        for (int i = 0; i < 8; i++) pat = {pat[6:0], trace[i]};
        check_eq("sdm40_pattern", pat, 8'b0001_0001);

        // Full scale, then mute: zero from the second ce on.
        sound = 8'hFF;
        run(16, 0, h, fh, lh, fc, lf);
        check_eq("sdmff_highs16", h, 15);
        mute = 1'b1;
        run(1, 0, h, fh, lh, fc, lf);
        check_eq("mute_first_ce", h, 1);
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("mute_highs", h, 0);

        // Asynchronous reset with no clock edge.
        mute = 1'b0;
        mode = 1'b0;
        run(10, 0, h, fh, lh, fc, lf);
        check_eq("pre_arst_dac", dac_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_dac", dac_out, 0);
        #1 rst_n = 1'b1;
        run(256, 0, h, fh, lh, fc, lf);
        check_eq("pre_arst_fs", frame_start, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_fs", frame_start, 0);
        #1 rst_n = 1'b1;

        // Prescaler DIV=3, PWM level 2.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        run(768, 1, h, fh, lh, fc, lf);
        check_eq("div3_f1_highs", h, 0);
        check_eq("div3_f1_fs_cnt", fc, 1);
        check_eq("div3_f1_fs_pos", lf, 767);
        run(768, 1, h, fh, lh, fc, lf);
        check_eq("div3_f2_highs", h, 6);
        check_eq("div3_f2_first", fh, 2);
        check_eq("div3_f2_last", lh, 7);
        check_eq("div3_f2_fs_cnt", fc, 1);
        check_eq("div3_f2_fs_pos", lf, 767);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
